// File: rtl/rv32i_dec_if.sv
// Fetch-to-decode bundle: instruction word in, decoded fields and flags out.
// instr_id exists only when RV32I_DEC_INSTR_ID_EN is defined.
interface rv32i_dec_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] imm;
    logic            is_R;
    logic            is_I;
    logic            is_S;
    logic            is_B;
    logic            is_U;
    logic            is_J;
    logic            rs1_valid;
    logic            rs2_valid;
    logic            rd_valid;
    logic            imm_valid;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic [6:0]      opcode;
    logic            illegal;
`ifdef RV32I_DEC_INSTR_ID_EN
    logic [5:0]      instr_id;
`endif

    modport master (
        output instr,
        input  rs1, rs2, rd, imm,
        input  is_R, is_I, is_S, is_B, is_U, is_J,
        input  rs1_valid, rs2_valid, rd_valid, imm_valid,
        input  funct3, funct7_b5, opcode, illegal
`ifdef RV32I_DEC_INSTR_ID_EN
        , input instr_id
`endif
    );

    modport slave (
        input  instr,
        output rs1, rs2, rd, imm,
        output is_R, is_I, is_S, is_B, is_U, is_J,
        output rs1_valid, rs2_valid, rd_valid, imm_valid,
        output funct3, funct7_b5, opcode, illegal
`ifdef RV32I_DEC_INSTR_ID_EN
        , output instr_id
`endif
    );
endinterface

// File: rtl/rv32i_dec.sv
// RV32I format decoder: register indices, sign-extended immediate, field flags; RV32I_DEC_INSTR_ID_EN adds instr_id.
// Latency one clock, one instruction accepted every cycle, no backpressure.
module rv32i_dec #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    rv32i_dec_if.slave  dec
);

    typedef struct packed {
        logic r;
        logic i;
        logic s;
        logic b;
        logic u;
        logic j;
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            rd_valid;
        logic            imm_valid;
        logic [2:0]      funct3;
        logic            funct7_b5;
        logic [6:0]      opcode;
        logic            illegal;
`ifdef RV32I_DEC_INSTR_ID_EN
        logic [5:0]      instr_id;
`endif
    } dec_t;

    logic [XLEN-1:0] instr;
    logic [4:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    fmt_t            fmt;
    logic            writes_rd;
    dec_t            d;
    dec_t            q;
`ifdef RV32I_DEC_INSTR_ID_EN
    logic [5:0]      id;
`endif

    assign instr = dec.instr;
    assign op    = instr[6:2];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    always_comb begin
        fmt = '0;
        if (instr[1:0] == 2'b11) begin
            case (op)
                5'b01011, 5'b01100, 5'b01110, 5'b10100:          fmt.r = 1'b1;
                5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11001: fmt.i = 1'b1;
                5'b01000, 5'b01001:                              fmt.s = 1'b1;
                5'b11000:                                        fmt.b = 1'b1;
                5'b00101, 5'b01101:                              fmt.u = 1'b1;
                5'b11011:                                        fmt.j = 1'b1;
                default:                                         fmt   = '0;
            endcase
        end
`ifdef RV32I_DEC_INSTR_ID_EN
        id = 6'd0;
        case (op)
            5'b01101: id = 6'd1;
            5'b00101: id = 6'd2;
            5'b11011: id = 6'd3;
            5'b11001: id = (f3 == 3'b000) ? 6'd4 : 6'd0;
            5'b11000: case (f3)
                3'b000: id = 6'd5;
                3'b001: id = 6'd6;
                3'b100: id = 6'd7;
                3'b101: id = 6'd8;
                3'b110: id = 6'd9;
                3'b111: id = 6'd10;
                default: id = 6'd0;
            endcase
            5'b00000: case (f3)
                3'b000: id = 6'd11;
                3'b001: id = 6'd12;
                3'b010: id = 6'd13;
                3'b100: id = 6'd14;
                3'b101: id = 6'd15;
                default: id = 6'd0;
            endcase
            5'b01000: case (f3)
                3'b000: id = 6'd16;
                3'b001: id = 6'd17;
                3'b010: id = 6'd18;
                default: id = 6'd0;
            endcase
            5'b00100: case (f3)
                3'b000: id = 6'd19;
                3'b010: id = 6'd20;
                3'b011: id = 6'd21;
                3'b100: id = 6'd22;
                3'b110: id = 6'd23;
                3'b111: id = 6'd24;
                3'b001: id = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
                default: id = (f7 == 7'b0000000) ? 6'd26 :
                              (f7 == 7'b0100000) ? 6'd27 : 6'd0;
            endcase
            5'b01100: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  id = 6'd28;
                        3'b001:  id = 6'd30;
                        3'b010:  id = 6'd31;
                        3'b011:  id = 6'd32;
                        3'b100:  id = 6'd33;
                        3'b101:  id = 6'd34;
                        3'b110:  id = 6'd36;
                        default: id = 6'd37;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      id = 6'd29;
                    else if (f3 == 3'b101) id = 6'd35;
                end
            end
            default: id = 6'd0;
        endcase
        // A recognised format with no matching instruction is treated as undecodable.
        if (id == 6'd0) fmt = '0;
`endif
    end

    assign writes_rd = fmt.r | fmt.i | fmt.u | fmt.j;

    always_comb begin
        d           = '0;
        d.fmt       = fmt;
        d.funct3    = f3;
        d.funct7_b5 = instr[30];
        d.opcode    = instr[6:0];
        d.illegal   = (fmt == '0);
        d.rs1_valid = fmt.r | fmt.i | fmt.s | fmt.b;
        d.rs2_valid = fmt.r | fmt.s | fmt.b;
        d.rd_valid  = writes_rd && (instr[11:7] != 5'd0);
        d.imm_valid = fmt.i | fmt.s | fmt.b | fmt.u | fmt.j;
        if (d.rs1_valid) d.rs1[4:0] = instr[19:15];
        if (d.rs2_valid) d.rs2[4:0] = instr[24:20];
        if (writes_rd)   d.rd[4:0]  = instr[11:7];
        if (fmt.i)      d.imm = {{20{instr[31]}}, instr[31:20]};
        else if (fmt.s) d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (fmt.b) d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (fmt.u) d.imm = {instr[31:12], 12'b0};
        else if (fmt.j) d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef RV32I_DEC_INSTR_ID_EN
        d.instr_id  = (fmt == '0) ? 6'd0 : id;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

    assign dec.rs1       = q.rs1;
    assign dec.rs2       = q.rs2;
    assign dec.rd        = q.rd;
    assign dec.imm       = q.imm;
    assign dec.is_R      = q.fmt.r;
    assign dec.is_I      = q.fmt.i;
    assign dec.is_S      = q.fmt.s;
    assign dec.is_B      = q.fmt.b;
    assign dec.is_U      = q.fmt.u;
    assign dec.is_J      = q.fmt.j;
    assign dec.rs1_valid = q.rs1_valid;
    assign dec.rs2_valid = q.rs2_valid;
    assign dec.rd_valid  = q.rd_valid;
    assign dec.imm_valid = q.imm_valid;
    assign dec.funct3    = q.funct3;
    assign dec.funct7_b5 = q.funct7_b5;
    assign dec.opcode    = q.opcode;
    assign dec.illegal   = q.illegal;
`ifdef RV32I_DEC_INSTR_ID_EN
    assign dec.instr_id  = q.instr_id;
`endif

endmodule

// File: tb/tb_rv32i_dec.sv
// Scoreboard bench for rv32i_dec: driver queues expected decodes, monitor checks one clock later.
module tb_rv32i_dec;
    logic clk = 1'b0;
    logic reset;

    rv32i_dec_if #(.XLEN(32)) dif ();
    rv32i_dec #(.XLEN(32)) u_dut (.clk(clk), .reset(reset), .dec(dif.slave));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rd;
        logic [31:0] imm;
        logic [5:0]  fmt;   // R I S B U J
        logic [3:0]  vld;   // rs1 rs2 rd imm
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [6:0]  opcode;
        logic        illegal;
    } obs_t;

    localparam logic [31:0] R_OPS = 32'h0010_5800;
    localparam logic [31:0] I_OPS = 32'h0200_0053;
    localparam logic [31:0] S_OPS = 32'h0000_0300;
    localparam logic [31:0] B_OPS = 32'h0100_0000;
    localparam logic [31:0] U_OPS = 32'h0000_2020;
    localparam logic [31:0] J_OPS = 32'h0800_0000;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic obs_t observe();
        obs_t o;
        o.rs1       = dif.rs1;
        o.rs2       = dif.rs2;
        o.rd        = dif.rd;
        o.imm       = dif.imm;
        o.fmt       = {dif.is_R, dif.is_I, dif.is_S, dif.is_B, dif.is_U, dif.is_J};
        o.vld       = {dif.rs1_valid, dif.rs2_valid, dif.rd_valid, dif.imm_valid};
        o.funct3    = dif.funct3;
        o.funct7_b5 = dif.funct7_b5;
        o.opcode    = dif.opcode;
        o.illegal   = dif.illegal;
        return o;
    endfunction

    function automatic obs_t hand(input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] rd, input logic [31:0] imm,
                                  input logic [5:0] fmt, input logic [3:0] vld,
                                  input logic [2:0] f3, input logic f7b5,
                                  input logic [6:0] opc, input logic ill);
        obs_t o;
        o = '{rs1: rs1, rs2: rs2, rd: rd, imm: imm, fmt: fmt, vld: vld,
              funct3: f3, funct7_b5: f7b5, opcode: opc, illegal: ill};
        return o;
    endfunction

    // Reference decode for the opcode sweep, built from per-format opcode masks.
    function automatic obs_t model(input logic [31:0] w);
        obs_t o;
        logic [4:0] op;
        logic q, r, i, s, b, u, j;
        op = w[6:2];
        q  = (w[1:0] == 2'b11);
        r  = q & R_OPS[op];
        i  = q & I_OPS[op];
        s  = q & S_OPS[op];
        b  = q & B_OPS[op];
        u  = q & U_OPS[op];
        j  = q & J_OPS[op];
        o = '0;
        o.fmt       = {r, i, s, b, u, j};
        o.illegal   = !(r | i | s | b | u | j);
        o.funct3    = w[14:12];
        o.funct7_b5 = w[30];
        o.opcode    = w[6:0];
        o.vld       = {r | i | s | b, r | s | b, (r | i | u | j) && (w[11:7] != 0), i | s | b | u | j};
        o.rs1       = o.vld[3] ? {27'b0, w[19:15]} : 32'b0;
        o.rs2       = o.vld[2] ? {27'b0, w[24:20]} : 32'b0;
        o.rd        = (r | i | u | j) ? {27'b0, w[11:7]} : 32'b0;
        if (i) o.imm = $signed(w) >>> 20;
        if (s) o.imm = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
        if (b) o.imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
        if (u) o.imm = {w[31:12], 12'b0};
        if (j) o.imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11;
        return o;
    endfunction

    task automatic drive(input logic rst, input logic [31:0] w, input obs_t e, input string nm);
        reset     = rst;
        dif.instr = w;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin : monitor
        obs_t  e;
        obs_t  g;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                g  = observe();
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", nm, g, e);
                end
            end
        end
    end

    initial begin : driver
        obs_t  zero;
        string nm;
        logic [31:0] w;
        zero = '0;
        drive(1'b1, 32'hDEAD_BEEF, zero, "reset");
        drive(1'b0, 32'h0000_0013,
              hand(0, 0, 0, 0, 6'b010000, 4'b1001, 3'd0, 1'b0, 7'h13, 1'b0), "addi_x0");
        drive(1'b0, 32'h0020_81B3,
              hand(1, 2, 3, 0, 6'b100000, 4'b1110, 3'd0, 1'b0, 7'h33, 1'b0), "add");
        drive(1'b0, 32'hFFF1_0093,
              hand(2, 0, 1, 32'hFFFF_FFFF, 6'b010000, 4'b1011, 3'd0, 1'b1, 7'h13, 1'b0), "addi_neg");
        drive(1'b0, 32'h0051_2423,
              hand(2, 5, 0, 8, 6'b001000, 4'b1101, 3'd2, 1'b0, 7'h23, 1'b0), "sw");
        drive(1'b0, 32'hFE00_0EE3,
              hand(0, 0, 0, 32'hFFFF_FFFC, 6'b000100, 4'b1101, 3'd0, 1'b1, 7'h63, 1'b0), "beq");
        drive(1'b0, 32'h1234_51B7,
              hand(0, 0, 3, 32'h1234_5000, 6'b000010, 4'b0011, 3'd5, 1'b0, 7'h37, 1'b0), "lui");
        drive(1'b0, 32'h0080_00EF,
              hand(0, 0, 1, 8, 6'b000001, 4'b0011, 3'd0, 1'b0, 7'h6F, 1'b0), "jal");
        // Reset must win over a legal instruction, then decode resumes on the next edge.
        drive(1'b1, 32'h0020_81B3, zero, "reset_prio");
        drive(1'b0, 32'h0020_81B3,
              hand(1, 2, 3, 0, 6'b100000, 4'b1110, 3'd0, 1'b0, 7'h33, 1'b0), "add_after_reset");
        drive(1'b0, 32'h0000_0000,
              hand(0, 0, 0, 0, 6'b000000, 4'b0000, 3'd0, 1'b0, 7'h00, 1'b1), "all_zero_word");
        for (int op = 0; op < 32; op++) begin
            w  = 32'hC3A5_9E80 | (32'(op) << 2) | 32'h3;
            nm = $sformatf("sweep_op%0d", op);
            drive(1'b0, w, model(w), nm);
        end
        w = 32'hC3A5_9E80 | (32'd12 << 2);
        drive(1'b0, w, hand(0, 0, 0, 0, 6'b000000, 4'b0000, 3'd1, 1'b1, 7'h30, 1'b1), "quadrant00");
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_dec.md
Name: rv32i_dec

Overview:
- Registered RV32I instruction decoder between instruction fetch and register-file read / ALU in the pipeline.
- Classifies a 32-bit instruction word into R/I/S/B/U/J format.
- Extracts the rs1, rs2 and rd register indices.
- Builds the sign-extended 32-bit immediate.
- Flags which fields are meaningful, and flags undecodable words.

Parameters:
- XLEN, 32, datapath width of instr and imm; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word, sampled every rising edge.
- rs1  output  32  source register 1 index in [4:0]; [31:5] always 0.
- rs2  output  32  source register 2 index in [4:0]; [31:5] always 0.
- rd  output  32  destination register index in [4:0]; [31:5] always 0.
- imm  output  32  sign-extended immediate.
- is_R, is_I, is_S, is_B, is_U, is_J  output  1 each  format flags; one-hot, or all 0 when illegal.
- rs1_valid, rs2_valid, rd_valid, imm_valid  output  1 each  field-meaningful flags.
- funct3  output  3  instr[14:12].
- funct7_b5  output  1  instr[30].
- opcode  output  7  instr[6:0].
- illegal  output  1  instruction not decodable.

Behaviour:
- All outputs are registered, with a latency of one clock: the value of instr at rising edge N appears on the outputs after edge N.
- Reset (reset=1 at a rising edge): every output goes to 0, and illegal also goes to 0. Reset takes priority over decode. Deasserting reset resumes normal decode at the next edge.
- Format decode uses op = instr[6:2], and applies only when instr[1:0]==2'b11:
  - R when op is 01011, 01100, 01110 or 10100.
  - I when op is 00000, 00001, 00100, 00110 or 11001.
  - S when op is 01000 or 01001.
  - B when op is 11000.
  - U when op is 00101 or 01101.
  - J when op is 11011.
- illegal=1 when instr[1:0]!=2'b11 or op matches none of the sets above. In that case all format flags, valid flags, rs1, rs2, rd and imm are 0; funct3, funct7_b5 and opcode still reflect instr.
- Immediates (sign bit is instr[31]):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0.
- Valid flags:
  - rs1_valid = R|I|S|B.
  - rs2_valid = R|S|B.
  - rd_valid = (R|I|U|J) and instr[11:7]!=0; writes to x0 are not valid.
  - imm_valid = I|S|B|U|J.
- Field outputs: rs1 = instr[19:15] when rs1_valid, else 0. rs2 = instr[24:20] when rs2_valid, else 0. rd = instr[11:7] when (R|I|U|J), else 0; rd therefore shows 0 for x0 destinations.
- Back-to-back instructions every cycle are supported; there is no stall input and no handshake.

Optional Feature:
- Macro: RV32I_DEC_INSTR_ID_EN.
- Defined:
  - Adds output instr_id [5:0], registered with the same latency and reset to 0.
  - Numbering (0 = none):
    - LUI=1, AUIPC=2, JAL=3, JALR=4.
    - BEQ,BNE,BLT,BGE,BLTU,BGEU = 5-10.
    - LB,LH,LW,LBU,LHU = 11-15.
    - SB,SH,SW = 16-18.
    - ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI = 19-27.
    - ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND = 28-37.
  - Matching uses the opcode plus funct3, plus funct7 for shifts and R-type.
  - illegal is additionally set when a recognised format decodes to id 0. Examples: an 00110 opcode, or an invalid funct7.
- Not defined: no instr_id port; illegal is determined by opcode only.

Test Plan:
- reset=1 with any instr -> all outputs 0 on the next cycle; after release, 0x00000013 (addi x0,x0,0) -> is_I=1, rd_valid=0, imm=0.
- 0x002081B3 (add x3,x1,x2) -> is_R=1, rs1=1, rs2=2, rd=3, imm=0, imm_valid=0.
- 0xFFF10093 (addi x1,x2,-1) -> is_I=1, rs1=2, rd=1, imm=0xFFFFFFFF, rs2_valid=0.
- 0x00512423 (sw x5,8(x2)) -> is_S=1, rs1=2, rs2=5, imm=8, rd_valid=0; then 0xFE000EE3 (beq x0,x0,-4) -> is_B=1, imm=0xFFFFFFFC.
- 0x123451B7 (lui x3,0x12345) -> is_U=1, imm=0x12345000, rd=3; then 0x008000EF (jal x1,8) -> is_J=1, imm=8, rd=1.
- Sweep op[6:2] over all 32 values with instr[1:0]=11, then once with instr[1:0]=00 -> flags match the tables above exactly one-hot, and illegal=1 with zeroed fields otherwise; outputs lag instr by exactly one clock.
